fft_result_buffer: RTL and testbench
====================================

FFT_RESULT_BUFFER -- requirements
Module: fft_result_buffer

Interface
REQ-001 SHALL have parameter N, default 32: words per FFT frame.
REQ-002 SHALL have parameter MSB, default 8: bits per word.
REQ-003 SHALL have parameter HOLD_CYCLES, default 4096: cycles data_bus is frozen after each start_spi.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_data  input  MSB  FFT result word.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_last  input  1  marks final word of frame, qualified by in_valid.
REQ-009 SHALL have port in_ready  output  1  buffer accepts word this cycle.
REQ-010 SHALL have port err_clr  input  1  clears frame_err.
REQ-011 SHALL have port data_bus  output  N*MSB  committed frame, feeds serializer.
REQ-012 SHALL have port start_spi  output  1  one-cycle pulse: new frame on data_bus.
REQ-013 SHALL have port busy  output  1  hold counter nonzero.
REQ-014 SHALL have port frame_err  output  1  sticky framing error.

Function
REQ-015 SHALL accept a word on a rising edge where in_valid and in_ready are both 1.
REQ-016 SHALL write accepted word j (0-based within frame) into working buffer slice [(j+1)*MSB-1 : j*MSB].
REQ-017 SHALL keep word index idx (width clog2(N)), incremented per accepted word, wrapping N-1 -> 0.
REQ-018 SHALL implement states FILL, FULL, COMMIT.
REQ-019 FILL: in_ready=1; accepting word with idx=N-1 -> FULL; otherwise stay.
REQ-020 FULL: in_ready=0; if hold counter = 0 -> copy working buffer to data_bus, go COMMIT; else stay.
REQ-021 COMMIT: start_spi=1 for exactly this cycle, hold counter loaded with HOLD_CYCLES, in_ready=0, next state FILL.
REQ-022 Latency: word N-1 accepted at edge k, hold idle -> data_bus updated at edge k+1, start_spi high during cycle after edge k+1 (until edge k+2).
REQ-023 data_bus SHALL change only on the FULL->COMMIT transition; stable at all other times.
REQ-024 Hold counter SHALL decrement by 1 per cycle while nonzero, saturating at 0; busy = (counter != 0).
REQ-025 While busy, FILL SHALL continue accepting the next frame; only the FULL->COMMIT step waits.
REQ-026 in_last accepted with idx != N-1: SHALL set frame_err, discard partial frame, reset idx to 0, remain in FILL.
REQ-027 Word accepted at idx = N-1 with in_last=0: SHALL set frame_err but still commit the frame.
REQ-028 in_valid while in_ready=0: word ignored, no state change, no error.
REQ-029 err_clr=1 SHALL clear frame_err next edge; simultaneous new error SHALL win (frame_err stays 1).
REQ-030 HOLD_CYCLES = 0: commits SHALL be back-to-back limited only by FILL rate; start_spi never high two consecutive cycles.

Reset
REQ-031 rst_n=0 SHALL immediately force: state FILL, idx 0, hold counter 0, data_bus 0, working buffer 0, start_spi 0, busy 0, frame_err 0; in_ready 1 after release.
REQ-032 Reset mid-frame or mid-hold SHALL discard partial frame; no start_spi on release.
REQ-033 First accepted word after reset release SHALL be word 0.

Verification (N=4, MSB=8, HOLD_CYCLES=20)
REQ-034 Words 0x11,0x22,0x33,0x44 (last on 0x44), continuous valid -> data_bus=0x44332211 one edge later, single start_spi pulse, busy high 20 cycles.
REQ-035 Second frame 0xA1..0xA4 sent right after first start_spi -> accepted during busy, in_ready=0 until hold expires, then data_bus=0xA4A3A2A1, start_spi once; data_bus held at 0x44332211 throughout.
REQ-036 in_last on second word (0x55,0x66) -> frame_err=1, no start_spi; next full frame 0x01..0x04 commits as 0x04030201.
REQ-037 Four words with in_last never asserted -> frame_err=1, data_bus committed, start_spi pulsed; err_clr one cycle -> frame_err=0.
REQ-038 rst_n low after 2 words, then full frame 0x0A..0x0D -> data_bus=0x0D0C0B0A, no stale words, exactly one start_spi.
REQ-039 in_valid toggling randomly with random data over 50 frames -> each start_spi matches scoreboard frame, spacing between pulses >= 21 cycles.

Source files
------------

// File: rtl/fft_result_buffer.sv
// fft_result_buffer
// Collects a frame of N FFT result words from a valid/ready stream into a
// working buffer. Each complete frame is copied to data_bus, and start_spi
// pulses to announce it. After each commit, data_bus stays frozen for
// HOLD_CYCLES cycles so the downstream serializer can shift it out. During
// that hold the next frame keeps filling; only its commit waits for the hold
// to expire.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_data    FFT result word (MSB bits)
//   in_valid   in_data valid
//   in_last    final word of frame, qualified by in_valid
//   in_ready   buffer accepts a word this cycle
//   err_clr    clears frame_err
//   data_bus   committed frame (N*MSB bits), word j at [(j+1)*MSB-1 : j*MSB]
//   start_spi  one-cycle pulse: new frame on data_bus
//   busy       hold counter nonzero
//   frame_err  sticky framing error
module fft_result_buffer #(
    parameter int N           = 32,
    parameter int MSB         = 8,
    parameter int HOLD_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [MSB-1:0]   in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             err_clr,
    output logic [N*MSB-1:0] data_bus,
    output logic             start_spi,
    output logic             busy,
    output logic             frame_err
);

    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_FULL   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [IDX_W-1:0]   idx_r, idx_s;
    logic [N*MSB-1:0]   work_r, work_s;
    logic [N*MSB-1:0]   bus_r, bus_s;
    logic [HOLD_W-1:0]  hold_r, hold_s;
    logic               err_r, err_s;
    logic               err_new_s;
    logic               accept_s;
    logic               last_idx_s;

    // Next-state, datapath and error logic; all targets default to their current value.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        work_s     = work_r;
        bus_s      = bus_r;
        hold_s     = hold_r;
        err_new_s  = 1'b0;
        accept_s   = in_valid && (state_r == ST_FILL);
        last_idx_s = (idx_r == IDX_W'(N - 1));

        // Hold counter free-runs down to zero regardless of state.
        if (hold_r != {HOLD_W{1'b0}}) begin
            hold_s = hold_r - HOLD_W'(1);
        end else begin
            hold_s = hold_r;
        end

        case (state_r)
            ST_FILL: begin
                if (accept_s) begin
                    if (last_idx_s) begin
                        // Final slot: the frame is committed even when in_last is
                        // missing; the missing marker is only flagged.
                        work_s[idx_r*MSB +: MSB] = in_data;
                        idx_s                    = {IDX_W{1'b0}};
                        state_s                  = ST_FULL;
                        err_new_s                = !in_last;
                    end else if (in_last) begin
                        // Early in_last: drop the partial frame and restart at word 0.
                        idx_s     = {IDX_W{1'b0}};
                        err_new_s = 1'b1;
                    end else begin
                        work_s[idx_r*MSB +: MSB] = in_data;
                        idx_s                    = idx_r + IDX_W'(1);
                    end
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_FULL: begin
                if (hold_r == {HOLD_W{1'b0}}) begin
                    bus_s   = work_r;
                    state_s = ST_COMMIT;
                end else begin
                    state_s = ST_FULL;
                end
            end
            ST_COMMIT: begin
                hold_s  = HOLD_W'(HOLD_CYCLES);
                state_s = ST_FILL;
            end
            default: begin
                state_s = ST_FILL;
                idx_s   = {IDX_W{1'b0}};
            end
        endcase

        // A new error takes priority over a simultaneous clear.
        if (err_new_s) begin
            err_s = 1'b1;
        end else if (err_clr) begin
            err_s = 1'b0;
        end else begin
            err_s = err_r;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FILL;
            idx_r   <= {IDX_W{1'b0}};
            work_r  <= {(N*MSB){1'b0}};
            bus_r   <= {(N*MSB){1'b0}};
            hold_r  <= {HOLD_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            work_r  <= work_s;
            bus_r   <= bus_s;
            hold_r  <= hold_s;
            err_r   <= err_s;
        end
    end

    assign in_ready  = (state_r == ST_FILL);
    assign start_spi = (state_r == ST_COMMIT);
    assign busy      = (hold_r != {HOLD_W{1'b0}});
    assign data_bus  = bus_r;
    assign frame_err = err_r;

endmodule

// File: tb/tb_fft_result_buffer.sv
`timescale 1ns/1ps
module tb_fft_result_buffer;

    localparam int N    = 4;
    localparam int MSB  = 8;
    localparam int HOLD = 20;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [MSB-1:0]   in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic             err_clr = 1'b0;
    logic [N*MSB-1:0] data_bus;
    logic             start_spi;
    logic             busy;
    logic             frame_err;

    fft_result_buffer #(.N(N), .MSB(MSB), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .err_clr(err_clr),
        .data_bus(data_bus), .start_spi(start_spi), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state: words of the frame being assembled, committed frames.
    logic [MSB-1:0]   cur_q[$];
    logic [N*MSB-1:0] exp_q[$];
    logic             exp_err = 1'b0;
    int               exp_pulses = 0;
    int               pulses = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every start_spi and checks bus stability,
    // pulse spacing and the busy window length.
    int               cyc = 0;
    int               last_pulse = -1;
    int               busy_run = 0;
    logic [N*MSB-1:0] prev_bus = '0;
    logic             prev_spi = 1'b0;
    logic [N*MSB-1:0] exp_frame;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_bus   = '0;
            prev_spi   = 1'b0;
            busy_run   = 0;
            last_pulse = -1;
        end else begin
            if (!start_spi)
                chk("bus_stable", data_bus, prev_bus);
            if (start_spi) begin
                pulses++;
                chk("spi_not_consecutive", prev_spi, 1'b0);
                if (exp_q.size() == 0) begin
                    chk("spi_unexpected", 1'b1, 1'b0);
                end else begin
                    exp_frame = exp_q.pop_front();
                    chk("commit_data", data_bus, exp_frame);
                end
                if (last_pulse >= 0)
                    chk("pulse_spacing_ok", (cyc - last_pulse) >= HOLD + 1, 1'b1);
                last_pulse = cyc;
            end
            if (busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                chk("busy_len", busy_run, HOLD);
                busy_run = 0;
            end
            prev_bus = data_bus;
            prev_spi = start_spi;
        end
    end

    // Present one word from a negedge, wait for acceptance, update the model,
    // return at the following negedge after checking frame_err.
    task automatic send(input logic [MSB-1:0] d, input logic last, input logic clr);
        logic rdy;
        logic acc;
        logic new_err;
        logic [N*MSB-1:0] frame;
        int n;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        err_clr  = clr;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 300) begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) acc = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        if (!acc) begin
            chk("accept_timeout", 1'b0, 1'b1);
            in_valid = 1'b0;
            err_clr  = 1'b0;
            return;
        end
        new_err = 1'b0;
        cur_q.push_back(d);
        if (cur_q.size() == N) begin
            if (!last) new_err = 1'b1;
            frame = '0;
            for (int i = 0; i < N; i++) frame[i*MSB +: MSB] = cur_q[i];
            exp_q.push_back(frame);
            exp_pulses++;
            cur_q.delete();
        end else if (last) begin
            new_err = 1'b1;
            cur_q.delete();
        end
        if (new_err) exp_err = 1'b1;
        else if (clr) exp_err = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        err_clr  = 1'b0;
        chk("frame_err", frame_err, exp_err);
    endtask

    task automatic send_frame(input logic [MSB-1:0] base);
        for (int i = 0; i < N; i++) send(base + MSB'(i), i == N - 1, 1'b0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy || !in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", n < 500, 1'b1);
        @(negedge clk);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_err = 1'b0;
        chk("err_cleared", frame_err, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_bus", data_bus, '0);
        chk("rst_spi", start_spi, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        cur_q.delete();
        exp_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ready", in_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int p0;

    initial begin
        @(negedge clk);
        do_reset();
        @(negedge clk);

        // Basic frame with latency check.
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h33, 1'b0, 1'b0);
        send(8'h44, 1'b1, 1'b0);
        chk("lat_spi_early", start_spi, 1'b0);
        chk("lat_bus_early", data_bus, 32'h0);
        @(negedge clk);
        chk("lat_spi", start_spi, 1'b1);
        chk("lat_bus", data_bus, 32'h44332211);

        // Second frame accepted during the hold, commit waits for hold expiry.
        send(8'hA1, 1'b0, 1'b0);
        send(8'hA2, 1'b0, 1'b0);
        send(8'hA3, 1'b0, 1'b0);
        send(8'hA4, 1'b1, 1'b0);
        chk("hold_busy", busy, 1'b1);
        chk("hold_not_ready", in_ready, 1'b0);
        chk("hold_bus", data_bus, 32'h44332211);
        wait_idle();
        chk("two_pulses", pulses, 2);

        // Early in_last: error, no commit, then a clean frame.
        p0 = pulses;
        send(8'h55, 1'b0, 1'b0);
        send(8'h66, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("early_last_no_spi", pulses, p0);
        send_frame(8'h01);
        wait_idle();
        chk("bus_after_err", data_bus, 32'h04030201);
        clear_err();

        // Missing in_last: error but committed; clear.
        for (int i = 0; i < N; i++) send(8'hC0 + 8'(i), 1'b0, 1'b0);
        wait_idle();
        chk("nolast_bus", data_bus, 32'hC3C2C1C0);
        clear_err();

        // Clear coinciding with a new error: error wins.
        send(8'h77, 1'b1, 1'b1);
        chk("err_wins", frame_err, 1'b1);
        clear_err();

        // Reset mid-frame.
        send(8'hEE, 1'b0, 1'b0);
        send(8'hEF, 1'b0, 1'b0);
        do_reset();
        p0 = pulses;
        send_frame(8'h0A);
        wait_idle();
        chk("post_rst_bus", data_bus, 32'h0D0C0B0A);
        chk("post_rst_one_spi", pulses, p0 + 1);

        // Reset mid-hold: no pulse on release.
        send_frame(8'h30);
        repeat (6) @(negedge clk);
        do_reset();
        p0 = pulses;
        repeat (30) @(negedge clk);
        chk("rst_hold_no_spi", pulses, p0);

        // Random traffic.
        for (int f = 0; f < 50; f++) begin
            for (int w = 0; w < N; w++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send(MSB'($urandom), w == N - 1, 1'b0);
            end
        end
        wait_idle();

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("pulse_total", pulses, exp_pulses);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
